battleship_turn_ctrl: RTL and testbench

Turn scheduler and board-access arbiter for the Battleship game. It alternates fire turns between the human player and the PC shot generator. It owns the single shared board-memory port that holds both 5×5 matrices of 3-bit cells, resolves each shot as hit, miss or invalid, counts hits per side, and declares the winner. It sits between the button/shot-generator front ends and the board storage that also feeds the winner logic and the VGA controller.

---
 rtl/battleship_turn_ctrl_if.sv | 42 ++++
 rtl/battleship_turn_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_battleship_turn_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/battleship_turn_ctrl_if.sv
// Signal bundle between the Battleship turn controller and its front ends, board storage and status consumers.
// master is the controller side; slave is the environment (buttons, shot generator, board RAM).
interface battleship_turn_ctrl_if;
    logic       start;
    logic       player_req;
    logic [2:0] player_row;
    logic [2:0] player_col;
    logic       player_ack;
    logic       pc_req;
    logic [2:0] pc_row;
    logic [2:0] pc_col;
    logic       pc_ack;
    logic       board_sel;
    logic [2:0] board_row;
    logic [2:0] board_col;
    logic       board_rd;
    logic [2:0] board_rdata;
    logic       board_wr;
    logic [2:0] board_wdata;
    logic       turn;
    logic       result_valid;
    logic [1:0] shot_result;
    logic       turn_timeout;
    logic [4:0] player_hits;
    logic [4:0] pc_hits;
    logic       game_over;
    logic       winner;

    modport master (
        input  start, player_req, player_row, player_col, pc_req, pc_row, pc_col, board_rdata,
        output player_ack, pc_ack, board_sel, board_row, board_col, board_rd, board_wr,
               board_wdata, turn, result_valid, shot_result, turn_timeout, player_hits,
               pc_hits, game_over, winner
    );

    modport slave (
        output start, player_req, player_row, player_col, pc_req, pc_row, pc_col, board_rdata,
        input  player_ack, pc_ack, board_sel, board_row, board_col, board_rd, board_wr,
               board_wdata, turn, result_valid, shot_result, turn_timeout, player_hits,
               pc_hits, game_over, winner
    );
endinterface

// File: rtl/battleship_turn_ctrl.sv
// Battleship turn scheduler: alternates player/PC shots over one shared board port,
// classifies each shot, keeps saturating hit counts and declares the winner.
module battleship_turn_ctrl #(
    parameter int SHIP_CELLS   = 15,
    parameter int TURN_TIMEOUT = 250_000_000
) (
    input  logic                   clk,
    input  logic                   rst,
    battleship_turn_ctrl_if.master bus
);
    localparam int                 TIMER_W    = $clog2(TURN_TIMEOUT);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TURN_TIMEOUT - 1);
    localparam logic [4:0]         HITS_MAX   = 5'(SHIP_CELLS);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        P_WAIT  = 3'd1,
        P_READ  = 3'd2,
        P_EVAL  = 3'd3,
        PC_WAIT = 3'd4,
        PC_READ = 3'd5,
        PC_EVAL = 3'd6,
        DONE    = 3'd7
    } state_t;

    state_t             state_r, state_s;
    logic [TIMER_W-1:0] timer_r;
    logic [2:0]         row_r, col_r;
    logic               sel_r, turn_r, winner_r, player_ack_r, pc_ack_r, timeout_r;
    logic [4:0]         player_hits_r, pc_hits_r, hits_upd_s;
    logic               player_ok_s, pc_ok_s, eval_s, cell_ship_s, cell_water_s;
    logic               start_s, player_accept_s, pc_accept_s, timeout_s, win_s, rd_s, wr_s;
    logic [2:0]         wdata_s;
    logic [1:0]         result_s;

    function automatic logic coord_ok(input logic [2:0] r, input logic [2:0] c);
        return (r <= 3'd4) && (c <= 3'd4);
    endfunction

    function automatic logic [4:0] sat_inc(input logic [4:0] h);
        return (h >= HITS_MAX) ? h : h + 5'd1;
    endfunction

    assign player_ok_s  = bus.player_req && coord_ok(bus.player_row, bus.player_col);
    assign pc_ok_s      = bus.pc_req && coord_ok(bus.pc_row, bus.pc_col);
    assign eval_s       = (state_r == P_EVAL) || (state_r == PC_EVAL);
    assign cell_water_s = (bus.board_rdata == 3'd0);
    assign cell_ship_s  = (bus.board_rdata >= 3'd1) && (bus.board_rdata <= 3'd5);

    // Shot classification: the only path from board_rdata straight to outputs.
    always_comb begin
        wr_s     = 1'b0;
        wdata_s  = 3'd0;
        result_s = 2'b00;
        if (eval_s) begin
            if (cell_water_s) begin
                wr_s     = 1'b1;
                wdata_s  = 3'd7;
                result_s = 2'b01;
            end else if (cell_ship_s) begin
                wr_s     = 1'b1;
                wdata_s  = 3'd6;
                result_s = 2'b10;
            end else begin
                result_s = 2'b11;
            end
        end else begin
            result_s = 2'b00;
        end
    end

    // Next-state and per-state strobes.
    always_comb begin
        state_s         = state_r;
        start_s         = 1'b0;
        player_accept_s = 1'b0;
        pc_accept_s     = 1'b0;
        timeout_s       = 1'b0;
        win_s           = 1'b0;
        rd_s            = 1'b0;
        hits_upd_s      = 5'd0;
        case (state_r)
            IDLE, DONE: begin
                if (bus.start) begin
                    start_s = 1'b1;
                    state_s = P_WAIT;
                end else begin
                    state_s = state_r;
                end
            end
            P_WAIT: begin
                // An acceptable request beats timer expiry in the same cycle.
                if (player_ok_s) begin
                    player_accept_s = 1'b1;
                    state_s         = P_READ;
                end else if (timer_r == TIMER_LAST) begin
                    timeout_s = 1'b1;
                    state_s   = PC_WAIT;
                end else begin
                    state_s = state_r;
                end
            end
            P_READ: begin
                rd_s    = 1'b1;
                state_s = P_EVAL;
            end
            P_EVAL: begin
                hits_upd_s = cell_ship_s ? sat_inc(player_hits_r) : player_hits_r;
                if (hits_upd_s == HITS_MAX) begin
                    win_s   = 1'b1;
                    state_s = DONE;
                end else if (!cell_ship_s && !cell_water_s) begin
                    state_s = P_WAIT;
                end else begin
                    state_s = PC_WAIT;
                end
            end
            PC_WAIT: begin
                if (pc_ok_s) begin
                    pc_accept_s = 1'b1;
                    state_s     = PC_READ;
                end else begin
                    state_s = state_r;
                end
            end
            PC_READ: begin
                rd_s    = 1'b1;
                state_s = PC_EVAL;
            end
            PC_EVAL: begin
                hits_upd_s = cell_ship_s ? sat_inc(pc_hits_r) : pc_hits_r;
                if (hits_upd_s == HITS_MAX) begin
                    win_s   = 1'b1;
                    state_s = DONE;
                end else if (!cell_ship_s && !cell_water_s) begin
                    state_s = PC_WAIT;
                end else begin
                    state_s = P_WAIT;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register, latched shot address, pulses, counters and turn timer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            timer_r       <= '0;
            row_r         <= 3'd0;
            col_r         <= 3'd0;
            sel_r         <= 1'b0;
            turn_r        <= 1'b0;
            winner_r      <= 1'b0;
            player_ack_r  <= 1'b0;
            pc_ack_r      <= 1'b0;
            timeout_r     <= 1'b0;
            player_hits_r <= 5'd0;
            pc_hits_r     <= 5'd0;
        end else begin
            state_r      <= state_s;
            player_ack_r <= player_accept_s;
            pc_ack_r     <= pc_accept_s;
            timeout_r    <= timeout_s;

            if (player_accept_s) begin
                sel_r <= 1'b1;
                row_r <= bus.player_row;
                col_r <= bus.player_col;
            end else if (pc_accept_s) begin
                sel_r <= 1'b0;
                row_r <= bus.pc_row;
                col_r <= bus.pc_col;
            end

            if (start_s) begin
                player_hits_r <= 5'd0;
                pc_hits_r     <= 5'd0;
            end else if (state_r == P_EVAL) begin
                player_hits_r <= hits_upd_s;
            end else if (state_r == PC_EVAL) begin
                pc_hits_r <= hits_upd_s;
            end

            if (win_s) begin
                winner_r <= (state_r == PC_EVAL);
            end

            // turn follows the state being entered; IDLE/DONE keep the last side.
            if ((state_s == P_WAIT) || (state_s == P_READ) || (state_s == P_EVAL)) begin
                turn_r <= 1'b0;
            end else if ((state_s == PC_WAIT) || (state_s == PC_READ) || (state_s == PC_EVAL)) begin
                turn_r <= 1'b1;
            end

            if ((state_r == P_WAIT) && (state_s == P_WAIT)) begin
                timer_r <= timer_r + TIMER_W'(1);
            end else begin
                timer_r <= '0;
            end
        end
    end

    assign bus.player_ack   = player_ack_r;
    assign bus.pc_ack       = pc_ack_r;
    assign bus.board_sel    = sel_r;
    assign bus.board_row    = row_r;
    assign bus.board_col    = col_r;
    assign bus.board_rd     = rd_s;
    assign bus.board_wr     = wr_s;
    assign bus.board_wdata  = wdata_s;
    assign bus.turn         = turn_r;
    assign bus.result_valid = eval_s;
    assign bus.shot_result  = result_s;
    assign bus.turn_timeout = timeout_r;
    assign bus.player_hits  = player_hits_r;
    assign bus.pc_hits      = pc_hits_r;
    assign bus.game_over    = (state_r == DONE);
    assign bus.winner       = winner_r;
endmodule

// File: tb/tb_battleship_turn_ctrl.sv
// Directed bench for battleship_turn_ctrl: board RAM model, scoreboard queue of expected
// shot outcomes popped when result_valid fires, immediate-assertion checks.
module tb_battleship_turn_ctrl;
    localparam int SHIP = 2;
    localparam int TT   = 16;

    typedef struct packed {
        logic [1:0] res;
        logic       wr;
        logic [2:0] wd;
        logic       sel;
        logic [2:0] r;
        logic [2:0] c;
    } exp_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   exp_hits [2];
    exp_t q [$];
    logic [2:0] gold [0:1][0:7][0:7];
    logic [2:0] mem  [0:1][0:7][0:7];
    logic [2:0] rdata_r;

    battleship_turn_ctrl_if bus();

    battleship_turn_ctrl #(.SHIP_CELLS(SHIP), .TURN_TIMEOUT(TT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Board RAM: one-cycle read latency, reloaded with the test layout during rst.
    always @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < 2; s++)
                for (int r = 0; r < 8; r++)
                    for (int c = 0; c < 8; c++)
                        mem[s][r][c] <= 3'd0;
            mem[1][1][1] <= 3'd3;
            mem[1][4][4] <= 3'd2;
            mem[1][0][1] <= 3'd6;
            mem[0][0][0] <= 3'd4;
            rdata_r      <= 3'd0;
        end else begin
            if (bus.board_wr) mem[bus.board_sel][bus.board_row][bus.board_col] <= bus.board_wdata;
            if (bus.board_rd) rdata_r <= mem[bus.board_sel][bus.board_row][bus.board_col];
        end
    end
    assign bus.board_rdata = rdata_r;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive a request and wait for its ack; returns in the READ cycle.
    task automatic fire(input bit who, input logic [2:0] r, input logic [2:0] c,
                        input bit track, output int waited);
        exp_t e;
        logic sel;
        logic ack;
        sel = ~who;
        if (track) begin
            e.sel = sel; e.r = r; e.c = c;
            if (gold[sel][r][c] == 3'd0) begin
                e.res = 2'b01; e.wr = 1'b1; e.wd = 3'd7; gold[sel][r][c] = 3'd7;
            end else if (gold[sel][r][c] <= 3'd5) begin
                e.res = 2'b10; e.wr = 1'b1; e.wd = 3'd6; gold[sel][r][c] = 3'd6;
                if (exp_hits[who] < SHIP) exp_hits[who]++;
            end else begin
                e.res = 2'b11; e.wr = 1'b0; e.wd = 3'd0;
            end
            q.push_back(e);
        end
        if (who == 1'b0) begin
            bus.player_row = r; bus.player_col = c; bus.player_req = 1'b1;
        end else begin
            bus.pc_row = r; bus.pc_col = c; bus.pc_req = 1'b1;
        end
        waited = 0;
        do begin
            tick();
            waited++;
            ack = (who == 1'b0) ? bus.player_ack : bus.pc_ack;
        end while (!ack && waited < 40);
        bus.player_req = 1'b0;
        bus.pc_req     = 1'b0;
        check("ack", ack, 1'b1);
        check("read_bus", {bus.board_rd, bus.board_wr, bus.board_sel, bus.board_row, bus.board_col},
              {1'b1, 1'b0, sel, r, c});
    endtask

    // Advance into the EVAL cycle and compare against the scoreboard head.
    task automatic eval_check();
        exp_t e;
        tick();
        check("result_valid", bus.result_valid, 1'b1);
        check("sb_nonempty", (q.size() > 0), 1'b1);
        if (q.size() > 0) begin
            e = q.pop_front();
            check("shot_result", bus.shot_result, e.res);
            check("board_wr", bus.board_wr, e.wr);
            if (e.wr) check("board_wdata", bus.board_wdata, e.wd);
            check("eval_addr", {bus.board_rd, bus.board_sel, bus.board_row, bus.board_col},
                  {1'b0, e.sel, e.r, e.c});
        end
    endtask

    task automatic shot(input bit who, input logic [2:0] r, input logic [2:0] c);
        int w;
        fire(who, r, c, 1'b1, w);
        eval_check();
        tick();
    endtask

    initial begin
        int   w;
        logic acc;
        total = 0; bad = 0;
        exp_hits[0] = 0; exp_hits[1] = 0;
        rst = 1'b1; bus.start = 1'b0;
        bus.player_req = 1'b0; bus.player_row = 3'd0; bus.player_col = 3'd0;
        bus.pc_req = 1'b0; bus.pc_row = 3'd0; bus.pc_col = 3'd0;
        for (int s = 0; s < 2; s++)
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++)
                    gold[s][r][c] = 3'd0;
        gold[1][1][1] = 3'd3;
        gold[1][4][4] = 3'd2;
        gold[1][0][1] = 3'd6;
        gold[0][0][0] = 3'd4;

        repeat (3) tick();
        rst = 1'b0;
        check("rst_bus", {bus.board_rd, bus.board_wr, bus.board_sel, bus.board_row, bus.board_col,
                          bus.board_wdata}, 12'h000);
        check("rst_pulses", {bus.player_ack, bus.pc_ack, bus.result_valid, bus.turn_timeout}, 4'h0);
        check("rst_status", {bus.turn, bus.game_over, bus.winner, bus.player_hits, bus.pc_hits}, 13'h0);

        bus.start = 1'b1; tick(); bus.start = 1'b0;
        check("start_turn", {bus.turn, bus.game_over}, 2'b00);

        // Wrong side and out-of-range requests must be ignored.
        bus.pc_req = 1'b1; bus.player_req = 1'b1; bus.player_row = 3'd5; bus.player_col = 3'd0;
        acc = 1'b0;
        repeat (5) begin
            tick();
            acc = acc | bus.player_ack | bus.pc_ack | bus.board_rd | bus.board_wr;
        end
        bus.pc_req = 1'b0; bus.player_req = 1'b0;
        check("arb_no_access", acc, 1'b0);

        shot(1'b0, 3'd2, 3'd3);
        check("miss_turn", bus.turn, 1'b1);
        check("miss_hits", bus.player_hits, exp_hits[0]);

        shot(1'b1, 3'd0, 3'd0);
        check("pc_hit_turn", bus.turn, 1'b0);
        check("pc_hits", bus.pc_hits, exp_hits[1]);

        shot(1'b0, 3'd0, 3'd1);
        check("invalid_turn", bus.turn, 1'b0);
        shot(1'b0, 3'd1, 3'd1);
        check("retry_turn", bus.turn, 1'b1);
        check("retry_hits", bus.player_hits, exp_hits[0]);

        shot(1'b1, 3'd2, 3'd2);
        repeat (TT - 1) tick();
        check("pre_timeout", {bus.turn_timeout, bus.turn}, 2'b00);
        tick();
        check("timeout_pulse", {bus.turn_timeout, bus.turn}, 2'b11);
        tick();
        check("timeout_one_cycle", bus.turn_timeout, 1'b0);

        shot(1'b1, 3'd3, 3'd3);
        repeat (TT - 1) tick();
        fire(1'b0, 3'd4, 3'd4, 1'b1, w);
        check("expiry_req_wins", w, 1);
        check("expiry_no_timeout", bus.turn_timeout, 1'b0);
        eval_check();
        tick();
        check("win_status", {bus.game_over, bus.winner}, 2'b10);
        check("win_hits", bus.player_hits, exp_hits[0]);

        bus.player_req = 1'b1; bus.player_row = 3'd2; bus.player_col = 3'd2; bus.pc_req = 1'b1;
        acc = 1'b0;
        repeat (5) begin
            tick();
            acc = acc | bus.player_ack | bus.pc_ack | bus.board_rd | ~bus.game_over;
        end
        bus.player_req = 1'b0; bus.pc_req = 1'b0;
        check("done_ignores_req", acc, 1'b0);

        bus.start = 1'b1; tick(); bus.start = 1'b0;
        exp_hits[0] = 0; exp_hits[1] = 0;
        check("restart", {bus.game_over, bus.turn, bus.player_hits, bus.pc_hits}, 12'h000);

        // Reset arriving while the read is outstanding.
        fire(1'b0, 3'd3, 3'd4, 1'b0, w);
        rst = 1'b1;
        tick();
        check("rst_mid_bus", {bus.board_rd, bus.board_wr, bus.result_valid, bus.board_sel,
                              bus.board_row, bus.board_col}, 9'h000);
        check("rst_mid_status", {bus.turn, bus.game_over, bus.player_ack, bus.player_hits}, 8'h00);
        tick();
        check("rst_mid_no_wr", bus.board_wr, 1'b0);
        rst = 1'b0;
        tick();
        check("sb_drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
